// File: rtl/addepadcrc_pkg.sv
// Shared Ethernet transmit/receive definitions.
//   - eth_state_t : frame sequencer states (2-bit encoding)
//   - CRC constants for the reflected IEEE 802.3 CRC-32
//   - ETH_MINLEN  : minimum frame length (bytes, excluding FCS)
package addepadcrc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        CRC  = 2'd3
    } eth_state_t;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Register value left after running the CRC over a frame plus its FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int unsigned ETH_MINLEN    = 60;

endpackage

// File: rtl/addepadcrc_crc32_bytestep.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (LSB first).
// Purely combinational; also used by the receive-side FCS checker.
//   crc_in  [31:0] : running CRC register before the byte
//   data_in [7:0]  : byte to fold in
//   crc_out [31:0] : running CRC register after the byte
module crc32_bytestep
    import addepadcrc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            // Feedback bit is the outgoing register LSB combined with the
            // data bit entering on this shift.
            if (crc_out[0] ^ data_in[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/addepadcrc.sv
// Transmit-path pad + FCS stage.
// Pads short frames with zero bytes up to MINLEN (optional) and appends the
// IEEE 802.3 CRC-32 FCS (optional). No backpressure: one output byte per i_ce.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_ce           : byte strobe, all state advances only when high
//   i_pad_en       : pad short frames (sampled at frame start)
//   i_crc_en       : append FCS (sampled at frame start)
//   i_v, i_byte    : contiguous input frame
//   o_v, o_byte    : output frame, one i_ce behind the input
//   o_err          : input byte dropped because the stage was busy
module addepadcrc
    import addepadcrc_pkg::*;
#(
    parameter int unsigned MINLEN = ETH_MINLEN
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_pad_en,
    input  logic       i_crc_en,
    input  logic       i_v,
    input  logic [7:0] i_byte,
    output logic       o_v,
    output logic [7:0] o_byte,
    output logic       o_err
);

    localparam logic [5:0] MINLEN_C = 6'(MINLEN);

    eth_state_t  state_reg, state_next;
    logic [31:0] crc_reg, crc_next;
    logic [5:0]  count_reg, count_next;
    logic [2:0]  idx_reg, idx_next;
    logic        prev_v_reg;
    logic        pad_en_reg, pad_en_next;
    logic        crc_en_reg, crc_en_next;
    logic        o_v_reg, o_v_next;
    logic [7:0]  o_byte_reg, o_byte_next;
    logic        o_err_reg, o_err_next;

    logic [31:0] step_crc_in, step_crc_out, fcs;
    logic [7:0]  step_byte, fcs_byte;
    logic [5:0]  count_inc;
    logic        start;

    // A frame starts only on a rising i_v; prev_v resets high so a frame
    // already in flight at reset release is ignored until i_v drops.
    assign start = i_v && !prev_v_reg;

    // Data bytes feed the CRC while accepted; pad bytes feed zeros.
    assign step_byte   = ((state_reg == IDLE) || (state_reg == DATA && i_v)) ? i_byte : 8'h00;
    assign step_crc_in = (state_reg == IDLE) ? CRC_INIT : crc_reg;

    crc32_bytestep u_crc_step (
        .crc_in  (step_crc_in),
        .data_in (step_byte),
        .crc_out (step_crc_out)
    );

    assign fcs       = ~crc_reg;
    assign count_inc = (count_reg == 6'd63) ? count_reg : count_reg + 6'd1;

    always_comb begin
        case (idx_reg[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        crc_next    = crc_reg;
        count_next  = count_reg;
        idx_next    = idx_reg;
        pad_en_next = pad_en_reg;
        crc_en_next = crc_en_reg;
        o_v_next    = o_v_reg;
        o_byte_next = o_byte_reg;
        o_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    o_v_next    = 1'b1;
                    o_byte_next = i_byte;
                    crc_next    = step_crc_out;
                    count_next  = 6'd1;
                    pad_en_next = i_pad_en;
                    crc_en_next = i_crc_en;
                    state_next  = DATA;
                end else begin
                    o_v_next    = 1'b0;
                    o_byte_next = 8'h00;
                    crc_next    = CRC_INIT;
                    count_next  = 6'd0;
                end
            end
            DATA: begin
                if (i_v) begin
                    o_v_next    = 1'b1;
                    o_byte_next = i_byte;
                    crc_next    = step_crc_out;
                    count_next  = count_inc;
                end else if (pad_en_reg && count_reg < MINLEN_C) begin
                    o_byte_next = 8'h00;
                    crc_next    = step_crc_out;
                    count_next  = count_inc;
                    state_next  = PAD;
                end else if (crc_en_reg) begin
                    o_byte_next = fcs[7:0];
                    idx_next    = 3'd1;
                    state_next  = CRC;
                end else begin
                    o_v_next    = 1'b0;
                    o_byte_next = 8'h00;
                    state_next  = IDLE;
                end
            end
            PAD: begin
                o_err_next = i_v;
                if (count_reg < MINLEN_C) begin
                    o_byte_next = 8'h00;
                    crc_next    = step_crc_out;
                    count_next  = count_inc;
                end else if (crc_en_reg) begin
                    o_byte_next = fcs[7:0];
                    idx_next    = 3'd1;
                    state_next  = CRC;
                end else begin
                    o_v_next    = 1'b0;
                    o_byte_next = 8'h00;
                    state_next  = IDLE;
                end
            end
            CRC: begin
                o_err_next = i_v;
                // idx==4 means all four FCS bytes have gone out.
                if (idx_reg == 3'd4) begin
                    o_v_next    = 1'b0;
                    o_byte_next = 8'h00;
                    state_next  = IDLE;
                end else begin
                    o_byte_next = fcs_byte;
                    idx_next    = idx_reg + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            crc_reg    <= CRC_INIT;
            count_reg  <= 6'd0;
            idx_reg    <= 3'd0;
            prev_v_reg <= 1'b1;
            pad_en_reg <= 1'b0;
            crc_en_reg <= 1'b0;
            o_v_reg    <= 1'b0;
            o_byte_reg <= 8'h00;
            o_err_reg  <= 1'b0;
        end else if (i_ce) begin
            state_reg  <= state_next;
            crc_reg    <= crc_next;
            count_reg  <= count_next;
            idx_reg    <= idx_next;
            prev_v_reg <= i_v;
            pad_en_reg <= pad_en_next;
            crc_en_reg <= crc_en_next;
            o_v_reg    <= o_v_next;
            o_byte_reg <= o_byte_next;
            o_err_reg  <= o_err_next;
        end
    end

    assign o_v    = o_v_reg;
    assign o_byte = o_byte_reg;
    assign o_err  = o_err_reg;

endmodule

// File: tb/tb_addepadcrc.sv
// Directed-vector bench for the pad + FCS transmit stage.
module tb_addepadcrc;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ce = 1'b0;
    logic       i_pad_en = 1'b0;
    logic       i_crc_en = 1'b0;
    logic       i_v = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_v;
    logic [7:0] o_byte;
    logic       o_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    int         fall_idx;
    int         hold_viol;
    int         err_seen;
    logic       cap_v;
    logic [7:0] cap_b;

    addepadcrc #(.MINLEN(60)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .i_pad_en (i_pad_en),
        .i_crc_en (i_crc_en),
        .i_v      (i_v),
        .i_byte   (i_byte),
        .o_v      (o_v),
        .o_byte   (o_byte),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    // Textbook reflected CRC-32 step: fold byte into low bits, then shift.
    function automatic logic [31:0] ref_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] residue_of_out();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (out_q[k]) c = ref_step(c, out_q[k]);
        return c;
    endfunction

    // One i_ce edge carrying (v, b), followed by gap-1 idle clocks during
    // which the outputs must not move.
    task automatic drive_ce(input int gap, input logic v, input logic [7:0] b);
        @(negedge i_clk);
        i_ce = 1'b1;
        i_v = v;
        i_byte = b;
        @(posedge i_clk);
        #1;
        cap_v = o_v;
        cap_b = o_byte;
        if (o_err === 1'b1) err_seen++;
        for (int g = 1; g < gap; g++) begin
            @(negedge i_clk);
            i_ce = 1'b0;
            @(posedge i_clk);
            #1;
            if (o_v !== cap_v || o_byte !== cap_b) hold_viol++;
        end
    endtask

    // Sends in_q as one frame after an idle i_ce and collects o_v bytes until
    // o_v falls (bounded). fall_idx = i_ce count from first data byte, 0 on timeout.
    task automatic run_frame(input int gap, input logic pad, input logic crc);
        int  n;
        bit  seen;
        out_q.delete();
        hold_viol = 0;
        err_seen = 0;
        fall_idx = 0;
        n = 0;
        seen = 0;
        i_pad_en = pad;
        i_crc_en = crc;
        drive_ce(gap, 1'b0, 8'h00);
        foreach (in_q[k]) begin
            drive_ce(gap, 1'b1, in_q[k]);
            n++;
            if (o_v === 1'b1) begin
                seen = 1;
                out_q.push_back(o_byte);
            end
        end
        for (int k = 0; k < 200; k++) begin
            drive_ce(gap, 1'b0, 8'h00);
            n++;
            if (o_v === 1'b1) begin
                seen = 1;
                out_q.push_back(o_byte);
            end else if (seen) begin
                fall_idx = n;
                break;
            end
        end
    endtask

    task automatic load_digits();
        in_q.delete();
        for (int k = 0; k < 9; k++) in_q.push_back(8'h31 + 8'(k));
    endtask

    task automatic test_reset();
        vectors++;
        if (o_v !== 1'b0 || o_byte !== 8'h00 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b byte=%h err=%b required v=0 byte=00 err=0", o_v, o_byte, o_err);
        end
        $display("reset: v=%b byte=%h err=%b", o_v, o_byte, o_err);
    endtask

    task automatic test_check_value();
        logic [7:0] exp1 [13];
        exp1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        load_digits();
        run_frame(1, 1'b0, 1'b1);
        vectors++;
        if (out_q.size() != 13) begin
            miscompares++;
            $display("FAIL digits_len: got %0d bytes required 13", out_q.size());
        end
        for (int k = 0; k < 13; k++) begin
            if (k < out_q.size()) begin
                vectors++;
                if (out_q[k] !== exp1[k]) begin
                    miscompares++;
                    $display("FAIL digits_byte%0d: got %h required %h", k, out_q[k], exp1[k]);
                end
            end
        end
        vectors++;
        if (fall_idx != 14) begin
            miscompares++;
            $display("FAIL digits_fall: o_v fell on i_ce %0d required 14", fall_idx);
        end
        $display("digits frame: %0d bytes out, o_v fell at i_ce %0d", out_q.size(), fall_idx);
    endtask

    task automatic test_pad_only();
        int nz;
        in_q.delete();
        in_q.push_back(8'hAB);
        run_frame(1, 1'b1, 1'b0);
        nz = 0;
        for (int k = 1; k < out_q.size(); k++) if (out_q[k] !== 8'h00) nz++;
        vectors++;
        if (out_q.size() != 60) begin
            miscompares++;
            $display("FAIL pad_len: got %0d bytes required 60", out_q.size());
        end
        vectors++;
        if (out_q.size() == 0 || out_q[0] !== 8'hAB) begin
            miscompares++;
            $display("FAIL pad_first: got %h required ab", (out_q.size() > 0) ? out_q[0] : 8'hxx);
        end
        vectors++;
        if (nz != 0) begin
            miscompares++;
            $display("FAIL pad_zeros: got %0d nonzero pad bytes required 0", nz);
        end
        vectors++;
        if (fall_idx != 61) begin
            miscompares++;
            $display("FAIL pad_fall: o_v fell on i_ce %0d required 61", fall_idx);
        end
        $display("pad-only frame: %0d bytes out", out_q.size());
    endtask

    task automatic test_minlen(input int len);
        in_q.delete();
        for (int k = 0; k < len; k++) in_q.push_back(8'(k * 7 + 3));
        run_frame(1, 1'b1, 1'b1);
        vectors++;
        if (out_q.size() != 64) begin
            miscompares++;
            $display("FAIL minlen%0d_len: got %0d bytes required 64", len, out_q.size());
        end
        vectors++;
        if (residue_of_out() !== 32'hDEBB20E3) begin
            miscompares++;
            $display("FAIL minlen%0d_residue: got %h required debb20e3", len, residue_of_out());
        end
        vectors++;
        if (out_q.size() > len && out_q[len] === 8'h00 && len >= 60) begin
            miscompares++;
            $display("FAIL minlen%0d_nopad: got pad byte 00 at %0d required FCS byte", len, len);
        end
        $display("frame len=%0d pad+crc: %0d bytes out, residue %h", len, out_q.size(), residue_of_out());
    endtask

    task automatic test_long();
        in_q.delete();
        for (int k = 0; k < 70; k++) in_q.push_back(8'(k + 1));
        run_frame(1, 1'b1, 1'b1);
        vectors++;
        if (out_q.size() != 74) begin
            miscompares++;
            $display("FAIL long_len: got %0d bytes required 74", out_q.size());
        end
        vectors++;
        if (residue_of_out() !== 32'hDEBB20E3) begin
            miscompares++;
            $display("FAIL long_residue: got %h required debb20e3", residue_of_out());
        end
        $display("70-byte frame: %0d bytes out", out_q.size());
    endtask

    task automatic test_ce_gap();
        in_q.delete();
        for (int k = 0; k < 20; k++) in_q.push_back(8'hC0 + 8'(k));
        run_frame(4, 1'b1, 1'b1);
        vectors++;
        if (hold_viol != 0) begin
            miscompares++;
            $display("FAIL cegap_hold: got %0d changes between strobes required 0", hold_viol);
        end
        vectors++;
        if (out_q.size() != 64) begin
            miscompares++;
            $display("FAIL cegap_len: got %0d bytes required 64", out_q.size());
        end
        vectors++;
        if (residue_of_out() !== 32'hDEBB20E3) begin
            miscompares++;
            $display("FAIL cegap_residue: got %h required debb20e3", residue_of_out());
        end
        $display("ce every 4th clock: %0d bytes out, %0d hold changes", out_q.size(), hold_viol);
    endtask

    task automatic test_busy_drop();
        logic [31:0] c;
        logic [31:0] f;
        logic [7:0]  exp_b [8];
        logic        exp_v [8];
        logic        exp_e [8];
        logic        sv [8];
        logic        sb_v [8];
        logic [7:0]  sb [8];
        logic        se [8];
        logic        drv_v [8];
        logic [7:0]  drv_b [8];
        c = 32'hFFFFFFFF;
        c = ref_step(c, 8'h11);
        c = ref_step(c, 8'h22);
        c = ref_step(c, 8'h33);
        f = ~c;
        drv_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        drv_b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_b = '{8'h11, 8'h22, 8'h33, f[7:0], f[15:8], f[23:16], f[31:24], 8'h00};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        i_pad_en = 1'b0;
        i_crc_en = 1'b1;
        hold_viol = 0;
        drive_ce(1, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            drive_ce(1, drv_v[k], drv_b[k]);
            sb_v[k] = o_v;
            sb[k] = o_byte;
            se[k] = o_err;
            sv[k] = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (sv[k]) begin
                vectors++;
                if (sb_v[k] !== exp_v[k] || sb[k] !== exp_b[k] || se[k] !== exp_e[k]) begin
                    miscompares++;
                    $display("FAIL busy_step%0d: got v=%b byte=%h err=%b required v=%b byte=%h err=%b",
                             k, sb_v[k], sb[k], se[k], exp_v[k], exp_b[k], exp_e[k]);
                end
                $display("busy step %0d: in v=%b %h -> out v=%b %h err=%b", k, drv_v[k], drv_b[k], sb_v[k], sb[k], se[k]);
            end
        end
        load_digits();
        run_frame(1, 1'b0, 1'b1);
        vectors++;
        if (out_q.size() != 13 || out_q[9] !== 8'h26 || out_q[12] !== 8'hCB) begin
            miscompares++;
            $display("FAIL busy_recover: got %0d bytes required 13 ending 26..cb", out_q.size());
        end
        vectors++;
        if (err_seen != 0) begin
            miscompares++;
            $display("FAIL busy_recover_err: got %0d error pulses required 0", err_seen);
        end
        $display("frame after drop: %0d bytes out", out_q.size());
    endtask

    task automatic test_reset_mid_frame();
        i_pad_en = 1'b0;
        i_crc_en = 1'b1;
        drive_ce(1, 1'b0, 8'h00);
        drive_ce(1, 1'b1, 8'h55);
        drive_ce(1, 1'b1, 8'h66);
        vectors++;
        if (o_v !== 1'b1 || o_byte !== 8'h66) begin
            miscompares++;
            $display("FAIL midreset_pre: got v=%b byte=%h required v=1 byte=66", o_v, o_byte);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        i_ce = 1'b1;
        i_v = 1'b1;
        i_byte = 8'h77;
        @(posedge i_clk);
        #1;
        vectors++;
        if (o_v !== 1'b0 || o_byte !== 8'h00 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_out: got v=%b byte=%h err=%b required v=0 byte=00 err=0", o_v, o_byte, o_err);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        i_ce = 1'b0;
        i_v = 1'b0;
        load_digits();
        run_frame(1, 1'b0, 1'b1);
        vectors++;
        if (out_q.size() != 13 || out_q[9] !== 8'h26 || out_q[10] !== 8'h39 ||
            out_q[11] !== 8'hF4 || out_q[12] !== 8'hCB) begin
            miscompares++;
            $display("FAIL midreset_fcs: got %0d bytes required 13 with FCS 26 39 f4 cb", out_q.size());
        end
        $display("frame after mid-frame reset: %0d bytes out", out_q.size());
    endtask

    initial begin
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        test_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        test_check_value();
        test_pad_only();
        test_minlen(60);
        test_minlen(14);
        test_long();
        test_ce_gap();
        test_busy_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addepadcrc.md
Name: addepadcrc

Overview:
- Transmit-path stage that sits directly downstream of the hardware-MAC insertion stage and upstream of the preamble stage.
- Takes a contiguous byte stream (i_v/i_byte, one byte per i_ce) and pads short frames with zeros to a minimum length.
- Appends the IEEE 802.3 CRC-32 FCS.
- No backpressure: output runs on the same i_ce cadence as the input.

Parameters:
- MINLEN, 60, minimum frame length in bytes (excluding FCS) before padding stops; legal range 1..63.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  byte strobe; all state advances only on cycles with i_ce=1
- i_pad_en  in  1  enable zero padding to MINLEN
- i_crc_en  in  1  enable FCS append
- i_v  in  1  input byte valid; high for the whole frame, contiguous
- i_byte  in  8  input byte
- o_v  out  1  output byte valid
- o_byte  out  8  output byte
- o_err  out  1  one-i_ce-cycle pulse: input byte dropped (frame arrived while busy)

Behaviour:
- Reset: state=IDLE, o_v=0, o_byte=0, o_err=0, crc=32'hFFFFFFFF, count=0. Reset mid-frame aborts the frame with no FCS. Frame start requires i_v=0 on at least one i_ce after reset.
- Nothing changes on cycles with i_ce=0. i_pad_en and i_crc_en are latched at frame start; mid-frame changes are ignored.
- Latency: one i_ce. Data byte on i_ce n appears on o_byte after that edge.
- Byte counter: 6 bits, saturates at 63; counts data and pad bytes.
- CRC: reflected poly 32'hEDB88320, init FFFFFFFF, bytewise LSB-first, updated with every data and pad byte as it is emitted. FCS = ~crc, emitted [7:0] first, then [15:8], [23:16], [31:24].
- prev_v holds i_v from the previous i_ce. A frame starts only on i_v=1 with prev_v=0.
- States, evaluated on each i_ce:
  - IDLE:
    - start condition true: o_v=1, o_byte=i_byte, crc=step(FFFFFFFF,i_byte), count=1, go to DATA.
    - otherwise: o_v=0, crc=FFFFFFFF.
  - DATA:
    - i_v=1: o_byte=i_byte, crc step, count++.
    - i_v=0 and pad_en and count<MINLEN: o_byte=0, crc step(0), count++, go to PAD.
    - i_v=0, else if crc_en: o_byte=~crc[7:0], idx=1, go to CRC.
    - i_v=0, else: o_v=0, go to IDLE.
  - PAD:
    - count<MINLEN: emit 0, crc step, count++.
    - count=MINLEN and crc_en: emit ~crc[7:0], idx=1, go to CRC.
    - count=MINLEN, else: o_v=0, go to IDLE.
  - CRC:
    - emit ~crc byte idx, idx++.
    - after idx=3 is emitted, the next i_ce sets o_v=0 and goes to IDLE.
- i_v=1 during PAD or CRC, or a new start while not IDLE: byte dropped, o_err=1 for that i_ce. The stage never restarts until i_v has been seen low in or after IDLE.
- Frames of at least MINLEN bytes get no padding. A 63+ byte frame leaves the count saturated and no pad is added.
- o_v is contiguous per frame. Frame length out = max(len, MINLEN if pad) + 4 if crc.

Decomposition:
- Shared ethernet package holds:
  - state encodings IDLE/DATA/PAD/CRC (2 bits)
  - CRC_POLY_REFL = 32'hEDB88320
  - CRC_INIT = 32'hFFFFFFFF
  - CRC_RESIDUE = 32'hDEBB20E3
  - ETH_MINLEN = 60
- One combinational sub-module, crc32_bytestep (crc_in[31:0], byte[7:0] -> crc_out[31:0]). It is reused by the receive-side CRC checker.

Test Plan:
- pad=0, crc=1, i_ce every clock, input ASCII "123456789" -> o_v for 13 bytes: 31..39 then 26 39 F4 CB; o_v falls on the 14th i_ce.
- pad=1, crc=0, 1-byte frame 0xAB -> 60 bytes out: AB followed by 59 x 00, then o_v=0.
- pad=1, crc=1, 60-byte frame -> no pad bytes, 64 bytes out. Running step over all 64 output bytes yields residue DEBB20E3. Repeat with a 14-byte frame -> 64 bytes out, same residue.
- i_ce every 4th clock, 20-byte frame with pad and crc -> outputs change only on i_ce edges and hold 3 clocks each; 64 bytes out; o_v never drops mid-frame.
- New frame raised during the CRC of the prior frame -> its bytes are dropped, o_err pulses on each dropped byte, no output. After i_v goes low for one i_ce, the next frame is processed normally.
- i_reset asserted mid-DATA -> next clock o_v=0, o_byte=0, o_err=0. A following frame gets a CRC identical to the same frame sent after a clean reset.
